// File: rtl/csr_matrix_writer.sv
// Streaming dense-to-CSR encoder: writes row pointers and column indices on
// port 1 and nonzero values on port 2 while a row-major matrix streams in.
module csr_matrix_writer #(
    parameter int N_ROWS = 16,
    parameter int N_COLS = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [31:0] row_base,
    input  logic [31:0] wdata_col_base,
    input  logic [31:0] matrix_base,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] addr1,
    output logic [31:0] dataOut1,
    output logic        WR1,
    output logic [31:0] addr2,
    output logic [31:0] dataOut2,
    output logic        WR2,
    output logic [31:0] nnz,
    output logic        busy,
    output logic        done
);

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ROWPTR = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [RW-1:0] row_r, row_s;
    logic [CW-1:0] col_r, col_s;
    logic [31:0]   row_base_r, row_base_s;
    logic [31:0]   col_base_r, col_base_s;
    logic [31:0]   mat_base_r, mat_base_s;
    logic [31:0]   addr1_s, data1_s, addr2_s, data2_s, nnz_s;
    logic          wr1_s, wr2_s, busy_s, done_s;

    assign din_ready = (state_r == STREAM);

    // Next-state and next-output computation for the encoder FSM.
    always_comb begin
        state_s    = state_r;
        row_s      = row_r;
        col_s      = col_r;
        row_base_s = row_base_r;
        col_base_s = col_base_r;
        mat_base_s = mat_base_r;
        addr1_s    = addr1;
        data1_s    = dataOut1;
        addr2_s    = addr2;
        data2_s    = dataOut2;
        nnz_s      = nnz;
        wr1_s      = 1'b0;
        wr2_s      = 1'b0;
        busy_s     = busy;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                // The done cycle is already IDLE; a start there must not launch a new matrix.
                if (start && !done) begin
                    row_base_s = row_base;
                    col_base_s = wdata_col_base;
                    mat_base_s = matrix_base;
                    row_s      = '0;
                    col_s      = '0;
                    nnz_s      = 32'd0;
                    addr1_s    = row_base;
                    data1_s    = 32'd0;
                    wr1_s      = 1'b1;
                    busy_s     = 1'b1;
                    state_s    = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (din_valid) begin
                    if (din != 32'd0) begin
                        addr1_s = col_base_r + nnz;
                        data1_s = 32'(col_r);
                        wr1_s   = 1'b1;
                        addr2_s = mat_base_r + nnz;
                        data2_s = din;
                        wr2_s   = 1'b1;
                        nnz_s   = nnz + 32'd1;
                    end else begin
                        nnz_s = nnz;
                    end
                    if (col_r == COL_LAST) begin
                        col_s   = '0;
                        state_s = ROWPTR;
                    end else begin
                        col_s = col_r + CW'(1);
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            ROWPTR: begin
                addr1_s = row_base_r + 32'(row_r) + 32'd1;
                data1_s = nnz;
                wr1_s   = 1'b1;
                if (row_r == ROW_LAST) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    row_s   = row_r + RW'(1);
                    state_s = STREAM;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, counter, latched-base and registered-output update.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r    <= IDLE;
            row_r      <= '0;
            col_r      <= '0;
            row_base_r <= 32'd0;
            col_base_r <= 32'd0;
            mat_base_r <= 32'd0;
            addr1      <= 32'd0;
            dataOut1   <= 32'd0;
            WR1        <= 1'b0;
            addr2      <= 32'd0;
            dataOut2   <= 32'd0;
            WR2        <= 1'b0;
            nnz        <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            row_r      <= row_s;
            col_r      <= col_s;
            row_base_r <= row_base_s;
            col_base_r <= col_base_s;
            mat_base_r <= mat_base_s;
            addr1      <= addr1_s;
            dataOut1   <= data1_s;
            WR1        <= wr1_s;
            addr2      <= addr2_s;
            dataOut2   <= data2_s;
            WR2        <= wr2_s;
            nnz        <= nnz_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

endmodule

// File: tb/tb_csr_matrix_writer.sv
// Scoreboard bench for csr_matrix_writer: a 2x4 instance and a 16x16 instance
// share the clock and reset; expected port writes are queued as elements are fed.
module tb_csr_matrix_writer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        start_s     [2];
    logic [31:0] row_base_s  [2];
    logic [31:0] col_base_s  [2];
    logic [31:0] mat_base_s  [2];
    logic [31:0] din_s       [2];
    logic        din_valid_s [2];
    logic        din_ready_s [2];
    logic [31:0] addr1_s     [2];
    logic [31:0] data1_s     [2];
    logic        wr1_s       [2];
    logic [31:0] addr2_s     [2];
    logic [31:0] data2_s     [2];
    logic        wr2_s       [2];
    logic [31:0] nnz_s       [2];
    logic        busy_s      [2];
    logic        done_s      [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [64:0] q1 [$];
    logic [63:0] q2 [$];

    always #5 Clk = ~Clk;

    csr_matrix_writer #(.N_ROWS(2), .N_COLS(4)) u_small (
        .Clk(Clk), .Rst(Rst), .start(start_s[0]),
        .row_base(row_base_s[0]), .wdata_col_base(col_base_s[0]), .matrix_base(mat_base_s[0]),
        .din(din_s[0]), .din_valid(din_valid_s[0]), .din_ready(din_ready_s[0]),
        .addr1(addr1_s[0]), .dataOut1(data1_s[0]), .WR1(wr1_s[0]),
        .addr2(addr2_s[0]), .dataOut2(data2_s[0]), .WR2(wr2_s[0]),
        .nnz(nnz_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    csr_matrix_writer #(.N_ROWS(16), .N_COLS(16)) u_dense (
        .Clk(Clk), .Rst(Rst), .start(start_s[1]),
        .row_base(row_base_s[1]), .wdata_col_base(col_base_s[1]), .matrix_base(mat_base_s[1]),
        .din(din_s[1]), .din_valid(din_valid_s[1]), .din_ready(din_ready_s[1]),
        .addr1(addr1_s[1]), .dataOut1(data1_s[1]), .WR1(wr1_s[1]),
        .addr2(addr2_s[1]), .dataOut2(data2_s[1]), .WR2(wr2_s[1]),
        .nnz(nnz_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] elem(input int mode, input int i, input int j);
        logic [31:0] v;
        v = 32'd0;
        if (mode == 0) begin
            if (i == 0 && j == 1) v = 32'd5;
            else if (i == 0 && j == 3) v = 32'd7;
            else v = 32'd0;
        end else begin
            v = 32'(16 * i + j + 1);
        end
        return v;
    endfunction

    // Port monitor: every strobe pops the oldest expected write of its port.
    always @(negedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 2; i++) begin
                if (wr1_s[i]) begin
                    if (q1.size() == 0) check("p1_unexpected", 65'(wr1_s[i]), 65'd0);
                    else check("p1_write", {done_s[i], addr1_s[i], data1_s[i]}, q1.pop_front());
                end else if (done_s[i]) begin
                    check("done_without_rowptr", 65'(done_s[i]), 65'd0);
                end
                if (wr2_s[i]) begin
                    if (q2.size() == 0) check("p2_unexpected", 65'(wr2_s[i]), 65'd0);
                    else check("p2_write", 65'({addr2_s[i], data2_s[i]}), 65'(q2.pop_front()));
                end
            end
        end
    end

    task automatic check_reset_values(input int id);
        check("rst_din_ready", 65'(din_ready_s[id]), 65'd0);
        check("rst_port1", {wr1_s[id], addr1_s[id], data1_s[id]}, 65'd0);
        check("rst_port2", {wr2_s[id], addr2_s[id], data2_s[id]}, 65'd0);
        check("rst_status", {nnz_s[id], busy_s[id], done_s[id]}, 65'd0);
    endtask

    task automatic run(input int id, input int nrows, input int ncols, input int mode,
                       input logic [31:0] rb, input logic [31:0] cb, input logic [31:0] mb,
                       input int bp, input int misuse, input int stray_start,
                       input int abort_r, input int abort_c, input int exp_nnz);
        logic [31:0] v;
        int cyc;
        int nz;
        @(posedge Clk); #1;
        row_base_s[id] = rb;
        col_base_s[id] = cb;
        mat_base_s[id] = mb;
        start_s[id]    = 1'b1;
        q1.push_back({1'b0, rb, 32'd0});
        nz = 0;
        @(posedge Clk); #1;
        start_s[id] = 1'b0;
        check("start_busy", 65'(busy_s[id]), 65'd1);
        check("start_ready", 65'(din_ready_s[id]), 65'd1);
        check("start_nnz", 65'(nnz_s[id]), 65'd0);
        cyc = 0;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ncols; c++) begin
                if (r == abort_r && c == abort_c) begin
                    din_valid_s[id] = 1'b0;
                    @(negedge Clk); #2;
                    Rst = 1'b0;
                    #1;
                    check_reset_values(id);
                    q1.delete();
                    q2.delete();
                    @(posedge Clk); #1;
                    Rst = 1'b1;
                    @(posedge Clk); #1;
                    check("post_rst_ready", 65'(din_ready_s[id]), 65'd0);
                    return;
                end
                while (bp != 0 && $urandom_range(0, 2) == 0) begin
                    din_valid_s[id] = 1'b0;
                    din_s[id] = $urandom;
                    @(posedge Clk); #1;
                    cyc++;
                end
                v = elem(mode, r, c);
                din_s[id] = v;
                din_valid_s[id] = 1'b1;
                if (misuse != 0 && r == 2) begin
                    start_s[id]    = (c < 3) ? 1'b1 : 1'b0;
                    row_base_s[id] = 32'hDEAD_0000;
                    col_base_s[id] = 32'hBEEF_0000;
                    mat_base_s[id] = 32'hCAFE_0000;
                end
                check("accept_ready", 65'(din_ready_s[id]), 65'd1);
                if (v != 32'd0) begin
                    q1.push_back({1'b0, cb + 32'(nz), 32'(c)});
                    q2.push_back({mb + 32'(nz), v});
                    nz++;
                end
                if (c == ncols - 1)
                    q1.push_back({(r == nrows - 1) ? 1'b1 : 1'b0, rb + 32'(r) + 32'd1, 32'(nz)});
                @(posedge Clk); #1;
                cyc++;
                din_valid_s[id] = 1'b0;
                start_s[id] = 1'b0;
                if (c == ncols - 1) begin
                    check("row_gap_ready", 65'(din_ready_s[id]), 65'd0);
                    @(posedge Clk); #1;
                    cyc++;
                    if (r < nrows - 1) begin
                        check("row_gap_back", 65'(din_ready_s[id]), 65'd1);
                    end else begin
                        check("done_pulse", 65'({done_s[id], busy_s[id]}), 65'b11);
                        check("final_nnz", 65'(nnz_s[id]), 65'(exp_nnz));
                        if (bp == 0) check("latency", 65'(cyc), 65'(nrows * (ncols + 1)));
                    end
                end
            end
        end
        if (stray_start != 0) start_s[id] = 1'b1;
        @(posedge Clk); #1;
        start_s[id] = 1'b0;
        check("idle_after_done", 65'({busy_s[id], done_s[id], din_ready_s[id]}), 65'd0);
        @(posedge Clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            row_base_s[i] = 32'd0;
            col_base_s[i] = 32'd0;
            mat_base_s[i] = 32'd0;
            din_s[i] = 32'd0;
            din_valid_s[i] = 1'b0;
        end
        #12;
        check_reset_values(0);
        check_reset_values(1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("idle_ready", 65'(din_ready_s[1]), 65'd0);

        run(0, 2, 4, 0, 32'd14610, 32'd1410, 32'd90, 0, 0, 1, -1, -1, 2);
        run(1, 16, 16, 1, 32'd14610, 32'd1410, 32'd90, 0, 0, 0, -1, -1, 256);
        run(1, 16, 16, 1, 32'd14610, 32'd1410, 32'd90, 1, 0, 0, -1, -1, 256);
        run(1, 16, 16, 1, 32'h0000_1000, 32'h0000_2000, 32'hFFFF_FFF0, 0, 1, 0, -1, -1, 256);
        run(1, 16, 16, 1, 32'd500, 32'd600, 32'd700, 0, 0, 0, 5, 3, 256);
        run(1, 16, 16, 1, 32'd0, 32'd4096, 32'd8192, 0, 0, 0, -1, -1, 256);

        repeat (3) @(posedge Clk);
        #1;
        check("q1_drained", 65'(q1.size()), 65'd0);
        check("q2_drained", 65'(q2.size()), 65'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
